// File: rtl/bellek_asamasi_pkg.sv
// rtl/bellek_asamasi_pkg.sv - access-type and FSM state encodings for the memory stage
package bellek_paket;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ls_tur_e;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISTEK = 2'd1,
        YANIT = 2'd2,
        TAMAM = 2'd3
    } durum_e;

endpackage

// File: rtl/bellek_asamasi_hizalayici.sv
// rtl/bellek_asamasi_hizalayici.sv - byte-lane mask, store replication, load align/extend, misalign check
module bellek_hizalayici
    import bellek_paket::*;
(
    input  logic [2:0]  tur,
    input  logic [1:0]  adres_alt,
    input  logic [31:0] yazma_verisi,
    input  logic [31:0] okunan_kelime,
    output logic [3:0]  maske,
    output logic [31:0] yazma_kelimesi,
    output logic [31:0] yukleme_verisi,
    output logic        hizasiz
);

    logic [31:0] kaydirilmis;

    always_comb begin
        kaydirilmis    = okunan_kelime >> {adres_alt, 3'b000};
        maske          = 4'b1111;
        yazma_kelimesi = yazma_verisi;
        yukleme_verisi = kaydirilmis;
        hizasiz        = (adres_alt != 2'b00);
        case (tur)
            LS_B, LS_BU: begin
                maske          = 4'b0001 << adres_alt;
                yazma_kelimesi = {4{yazma_verisi[7:0]}};
                yukleme_verisi = {{24{kaydirilmis[7] & (tur == LS_B)}}, kaydirilmis[7:0]};
                hizasiz        = 1'b0;
            end
            LS_H, LS_HU: begin
                maske          = 4'b0011 << {adres_alt[1], 1'b0};
                yazma_kelimesi = {2{yazma_verisi[15:0]}};
                yukleme_verisi = {{16{kaydirilmis[15] & (tur == LS_H)}}, kaydirilmis[15:0]};
                hizasiz        = adres_alt[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bellek_asamasi.sv
// rtl/bellek_asamasi.sv - memory pipeline stage; optional response timeout via BELLEK_ZAMAN_ASIMI_EN
module bellek_asamasi
    import bellek_paket::*;
`ifdef BELLEK_ZAMAN_ASIMI_EN
#(
    parameter int ZAMAN_ASIMI = 64
)
`endif
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        durdur_i,
    input  logic [31:0] bellek_adresi_i,
    input  logic [31:0] bellek_veri_i,
    input  logic [2:0]  load_save_buyrugu_i,
    input  logic        bellekten_oku_i,
    input  logic        bellege_yaz_i,
    input  logic [31:0] hedef_yazmac_verisi_i,
    input  logic        yazmaca_yaz_i,
    input  logic [4:0]  hedef_yazmaci_i,
    output logic        veri_istek_gecerli_o,
    input  logic        veri_istek_hazir_i,
    output logic [31:0] veri_istek_adres_o,
    output logic        veri_istek_yaz_o,
    output logic [3:0]  veri_istek_maske_o,
    output logic [31:0] veri_istek_veri_o,
    input  logic        veri_yanit_gecerli_i,
    input  logic [31:0] veri_yanit_i,
    output logic        bellek_stall_o,
    output logic        hizasiz_hata_o,
    output logic [31:0] gy_veri_o,
    output logic        gy_yazmaca_yaz_o,
    output logic [4:0]  gy_hedef_yazmaci_o
);

    durum_e      durum;
    logic [2:0]  tur_r;
    logic [1:0]  idx_r;
    logic        yazma_r;
    logic        yy_r;
    logic [4:0]  rd_r;
    logic [31:0] sonuc_r;

    logic [2:0]  tur_sec;
    logic [1:0]  idx_sec;
    logic [3:0]  maske;
    logic [31:0] yazma_kelimesi;
    logic [31:0] yukleme_verisi;
    logic        hizasiz;
    logic        bellek_op;

    // Live inputs drive the aligner while idle; the latched access afterwards.
    assign tur_sec   = (durum == BOSTA) ? load_save_buyrugu_i : tur_r;
    assign idx_sec   = (durum == BOSTA) ? bellek_adresi_i[1:0] : idx_r;
    assign bellek_op = bellekten_oku_i | bellege_yaz_i;

    bellek_hizalayici u_hizalayici (
        .tur            (tur_sec),
        .adres_alt      (idx_sec),
        .yazma_verisi   (bellek_veri_i),
        .okunan_kelime  (veri_yanit_i),
        .maske          (maske),
        .yazma_kelimesi (yazma_kelimesi),
        .yukleme_verisi (yukleme_verisi),
        .hizasiz        (hizasiz)
    );

    assign bellek_stall_o = bellek_op && (durum != TAMAM) && !((durum == BOSTA) && hizasiz);

`ifdef BELLEK_ZAMAN_ASIMI_EN
    localparam int SAYAC_W = $clog2(ZAMAN_ASIMI + 1);
    logic [SAYAC_W-1:0] sayac;
    logic               bekliyor;
    assign bekliyor = ((durum == ISTEK) && !veri_istek_hazir_i) ||
                      ((durum == YANIT) && !veri_yanit_gecerli_i);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum                <= BOSTA;
            tur_r                <= 3'd0;
            idx_r                <= 2'd0;
            yazma_r              <= 1'b0;
            yy_r                 <= 1'b0;
            rd_r                 <= 5'd0;
            sonuc_r              <= 32'd0;
            veri_istek_gecerli_o <= 1'b0;
            veri_istek_adres_o   <= 32'd0;
            veri_istek_yaz_o     <= 1'b0;
            veri_istek_maske_o   <= 4'd0;
            veri_istek_veri_o    <= 32'd0;
            hizasiz_hata_o       <= 1'b0;
            gy_veri_o            <= 32'd0;
            gy_yazmaca_yaz_o     <= 1'b0;
            gy_hedef_yazmaci_o   <= 5'd0;
`ifdef BELLEK_ZAMAN_ASIMI_EN
            sayac                <= '0;
`endif
        end else begin
            hizasiz_hata_o <= 1'b0;
            case (durum)
                BOSTA: if (!durdur_i) begin
                    if (bellek_op && hizasiz) begin
                        hizasiz_hata_o   <= 1'b1;
                        gy_yazmaca_yaz_o <= 1'b0;
                    end else if (bellek_op) begin
                        tur_r                <= load_save_buyrugu_i;
                        idx_r                <= bellek_adresi_i[1:0];
                        yazma_r              <= bellege_yaz_i;
                        yy_r                 <= yazmaca_yaz_i & ~bellege_yaz_i;
                        rd_r                 <= hedef_yazmaci_i;
                        sonuc_r              <= hedef_yazmac_verisi_i;
                        veri_istek_gecerli_o <= 1'b1;
                        veri_istek_adres_o   <= {bellek_adresi_i[31:2], 2'b00};
                        veri_istek_yaz_o     <= bellege_yaz_i;
                        veri_istek_maske_o   <= bellege_yaz_i ? maske : 4'b0000;
                        veri_istek_veri_o    <= bellege_yaz_i ? yazma_kelimesi : 32'd0;
                        durum                <= ISTEK;
                    end else begin
                        gy_veri_o          <= hedef_yazmac_verisi_i;
                        gy_yazmaca_yaz_o   <= yazmaca_yaz_i;
                        gy_hedef_yazmaci_o <= hedef_yazmaci_i;
                    end
                end
                ISTEK: if (veri_istek_hazir_i) begin
                    veri_istek_gecerli_o <= 1'b0;
                    if (yazma_r) begin
                        durum <= TAMAM;
                    end else if (veri_yanit_gecerli_i) begin
                        sonuc_r <= yukleme_verisi;
                        durum   <= TAMAM;
                    end else begin
                        durum <= YANIT;
                    end
                end
                YANIT: if (veri_yanit_gecerli_i) begin
                    sonuc_r <= yukleme_verisi;
                    durum   <= TAMAM;
                end
                TAMAM: if (!durdur_i) begin
                    gy_veri_o          <= sonuc_r;
                    gy_yazmaca_yaz_o   <= yy_r;
                    gy_hedef_yazmaci_o <= rd_r;
                    durum              <= BOSTA;
                end
            endcase
`ifdef BELLEK_ZAMAN_ASIMI_EN
            // Abort overrides the case above: drop the request and retire without writeback.
            if (bekliyor) begin
                if (sayac == SAYAC_W'(ZAMAN_ASIMI - 1)) begin
                    sayac                <= '0;
                    veri_istek_gecerli_o <= 1'b0;
                    yy_r                 <= 1'b0;
                    hizasiz_hata_o       <= 1'b1;
                    durum                <= TAMAM;
                end else begin
                    sayac <= sayac + 1'b1;
                end
            end else begin
                sayac <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bellek_asamasi.sv
// tb/tb_bellek_asamasi.sv - self-checking bench for bellek_asamasi (vectors, corner sequences, random)
module tb_bellek_asamasi;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        durdur_i;
    logic [31:0] bellek_adresi_i;
    logic [31:0] bellek_veri_i;
    logic [2:0]  load_save_buyrugu_i;
    logic        bellekten_oku_i;
    logic        bellege_yaz_i;
    logic [31:0] hedef_yazmac_verisi_i;
    logic        yazmaca_yaz_i;
    logic [4:0]  hedef_yazmaci_i;
    logic        veri_istek_gecerli_o;
    logic        veri_istek_hazir_i;
    logic [31:0] veri_istek_adres_o;
    logic        veri_istek_yaz_o;
    logic [3:0]  veri_istek_maske_o;
    logic [31:0] veri_istek_veri_o;
    logic        veri_yanit_gecerli_i;
    logic [31:0] veri_yanit_i;
    logic        bellek_stall_o;
    logic        hizasiz_hata_o;
    logic [31:0] gy_veri_o;
    logic        gy_yazmaca_yaz_o;
    logic [4:0]  gy_hedef_yazmaci_o;

    always #5 clk_i = ~clk_i;

`ifdef BELLEK_ZAMAN_ASIMI_EN
    bellek_asamasi #(.ZAMAN_ASIMI(4)) dut (
`else
    bellek_asamasi dut (
`endif
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .durdur_i              (durdur_i),
        .bellek_adresi_i       (bellek_adresi_i),
        .bellek_veri_i         (bellek_veri_i),
        .load_save_buyrugu_i   (load_save_buyrugu_i),
        .bellekten_oku_i       (bellekten_oku_i),
        .bellege_yaz_i         (bellege_yaz_i),
        .hedef_yazmac_verisi_i (hedef_yazmac_verisi_i),
        .yazmaca_yaz_i         (yazmaca_yaz_i),
        .hedef_yazmaci_i       (hedef_yazmaci_i),
        .veri_istek_gecerli_o  (veri_istek_gecerli_o),
        .veri_istek_hazir_i    (veri_istek_hazir_i),
        .veri_istek_adres_o    (veri_istek_adres_o),
        .veri_istek_yaz_o      (veri_istek_yaz_o),
        .veri_istek_maske_o    (veri_istek_maske_o),
        .veri_istek_veri_o     (veri_istek_veri_o),
        .veri_yanit_gecerli_i  (veri_yanit_gecerli_i),
        .veri_yanit_i          (veri_yanit_i),
        .bellek_stall_o        (bellek_stall_o),
        .hizasiz_hata_o        (hizasiz_hata_o),
        .gy_veri_o             (gy_veri_o),
        .gy_yazmaca_yaz_o      (gy_yazmaca_yaz_o),
        .gy_hedef_yazmaci_o    (gy_hedef_yazmaci_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", ad, gercek, beklenen);
        end
    endtask

    task automatic adim();
        @(posedge clk_i);
        #1;
    endtask

    task automatic temizle();
        bellekten_oku_i       = 1'b0;
        bellege_yaz_i         = 1'b0;
        load_save_buyrugu_i   = 3'b010;
        bellek_adresi_i       = 32'd0;
        bellek_veri_i         = 32'd0;
        hedef_yazmac_verisi_i = 32'd0;
        yazmaca_yaz_i         = 1'b0;
        hedef_yazmaci_i       = 5'd0;
        veri_istek_hazir_i    = 1'b0;
        veri_yanit_gecerli_i  = 1'b0;
        veri_yanit_i          = 32'd0;
    endtask

    // Reference model: access width in bytes and the arithmetic it implies.
    function automatic int boyut(input logic [2:0] t);
        case (t)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic ref_hizasiz(input logic [2:0] t, input logic [31:0] a);
        return (a % boyut(t)) != 0;
    endfunction

    function automatic logic [3:0] ref_maske(input logic [2:0] t, input logic [31:0] a);
        logic [63:0] m;
        m = ((64'd1 << boyut(t)) - 64'd1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_yazma(input logic [2:0] t, input logic [31:0] d);
        if (boyut(t) == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (boyut(t) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_yukleme(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w);
        logic [63:0] v;
        int          bit_say;
        bit_say = 8 * boyut(t);
        v = ({32'd0, w} >> (8 * (a % 4))) & ((64'd1 << bit_say) - 64'd1);
        if ((t == 3'b000 || t == 3'b001) && v >= (64'd1 << (bit_say - 1)))
            v = v - (64'd1 << bit_say);
        return v[31:0];
    endfunction

    // One instruction through the stage: drives the memory side and checks request, stall count, result.
    task automatic islem(input logic t_oku, input logic t_yaz, input logic [2:0] t_tur,
                         input logic [31:0] t_adr, input logic [31:0] t_wdata, input logic [31:0] t_word,
                         input logic [31:0] t_alu, input logic [4:0] t_rd, input logic t_yy,
                         input int hg, input int yg, input logic e_hata, input logic [3:0] e_maske,
                         input logic [31:0] e_wdata, input logic [31:0] e_gy, input string ad);
        int n_stall;
        bit yazma;
        n_stall = 0;
        yazma   = t_yaz;
        bellekten_oku_i       = t_oku;
        bellege_yaz_i         = t_yaz;
        load_save_buyrugu_i   = t_tur;
        bellek_adresi_i       = t_adr;
        bellek_veri_i         = t_wdata;
        hedef_yazmac_verisi_i = t_alu;
        hedef_yazmaci_i       = t_rd;
        yazmaca_yaz_i         = t_yy;
        #1;
        if (!(t_oku || t_yaz)) begin
            chk({ad, " stall"}, 32'(bellek_stall_o), 32'd0);
            adim();
            chk({ad, " gy_veri"}, gy_veri_o, t_alu);
            chk({ad, " gy_rd"}, 32'(gy_hedef_yazmaci_o), 32'(t_rd));
            chk({ad, " gy_yy"}, 32'(gy_yazmaca_yaz_o), 32'(t_yy));
        end else if (e_hata) begin
            chk({ad, " stall"}, 32'(bellek_stall_o), 32'd0);
            adim();
            chk({ad, " hata"}, 32'(hizasiz_hata_o), 32'd1);
            chk({ad, " gecerli"}, 32'(veri_istek_gecerli_o), 32'd0);
            chk({ad, " gy_yy"}, 32'(gy_yazmaca_yaz_o), 32'd0);
            temizle();
            adim();
            chk({ad, " hata pulse"}, 32'(hizasiz_hata_o), 32'd0);
        end else begin
            if (bellek_stall_o) n_stall++;
            adim();
            chk({ad, " gecerli"}, 32'(veri_istek_gecerli_o), 32'd1);
            chk({ad, " adres"}, veri_istek_adres_o, t_adr & 32'hFFFF_FFFC);
            chk({ad, " yaz"}, 32'(veri_istek_yaz_o), 32'(yazma));
            chk({ad, " maske"}, 32'(veri_istek_maske_o), yazma ? 32'(e_maske) : 32'd0);
            if (yazma) chk({ad, " veri"}, veri_istek_veri_o, e_wdata);
            for (int i = 0; i < hg; i++) begin
                if (bellek_stall_o) n_stall++;
                adim();
            end
            chk({ad, " gecerli held"}, 32'(veri_istek_gecerli_o), 32'd1);
            if (bellek_stall_o) n_stall++;
            veri_istek_hazir_i = 1'b1;
            if (!yazma && yg == 0) begin
                veri_yanit_gecerli_i = 1'b1;
                veri_yanit_i         = t_word;
            end
            adim();
            veri_istek_hazir_i   = 1'b0;
            veri_yanit_gecerli_i = 1'b0;
            veri_yanit_i         = $urandom;
            chk({ad, " gecerli drop"}, 32'(veri_istek_gecerli_o), 32'd0);
            if (!yazma) begin
                for (int i = 0; i < yg; i++) begin
                    if (bellek_stall_o) n_stall++;
                    if (i == yg - 1) begin
                        veri_yanit_gecerli_i = 1'b1;
                        veri_yanit_i         = t_word;
                    end
                    adim();
                end
                veri_yanit_gecerli_i = 1'b0;
            end
            chk({ad, " stall in TAMAM"}, 32'(bellek_stall_o), 32'd0);
            chk({ad, " stall cycles"}, 32'(n_stall), 32'(2 + hg + (yazma ? 0 : yg)));
            adim();
            temizle();
            chk({ad, " gy_yy"}, 32'(gy_yazmaca_yaz_o), yazma ? 32'd0 : 32'(t_yy));
            if (!yazma) begin
                chk({ad, " gy_veri"}, gy_veri_o, e_gy);
                chk({ad, " gy_rd"}, 32'(gy_hedef_yazmaci_o), 32'(t_rd));
            end
        end
    endtask

    typedef struct {
        logic        oku, yaz;
        logic [2:0]  tur;
        logic [31:0] adr, wdata, word, alu;
        logic [4:0]  rd;
        logic        yy;
        int          hg, yg;
        logic        hata;
        logic [3:0]  maske;
        logic [31:0] wexp, gy;
    } vek_t;

    vek_t tablo[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  turler[5];
        logic [2:0]  t;
        logic [31:0] a, d, w, alu;
        logic        o, y, yy;
        logic [4:0]  rd;
        int          r;

        tablo[0]  = '{0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0, 5'd0, 1'b0, 0, 0, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
        tablo[1]  = '{1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF_FF00, 32'h0, 5'd5, 1'b1, 0, 2, 1'b0, 4'h0, 32'h0, 32'hFFFF_FF80};
        tablo[2]  = '{1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF_FF00, 32'h0, 5'd6, 1'b1, 0, 2, 1'b0, 4'h0, 32'h0, 32'h0000_0080};
        tablo[3]  = '{0, 1, 3'b001, 32'h12, 32'h0000_ABCD, 32'h0, 32'h0, 5'd0, 1'b0, 0, 0, 1'b0, 4'hC, 32'hABCD_ABCD, 32'h0};
        tablo[4]  = '{1, 0, 3'b001, 32'h11, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
        tablo[5]  = '{0, 0, 3'b010, 32'h0, 32'h0, 32'h0, 32'h55, 5'd7, 1'b1, 0, 0, 1'b0, 4'h0, 32'h0, 32'h55};
        tablo[6]  = '{1, 0, 3'b010, 32'h44, 32'h0, 32'h1234_5678, 32'h0, 5'd9, 1'b1, 1, 0, 1'b0, 4'h0, 32'h0, 32'h1234_5678};
        tablo[7]  = '{1, 0, 3'b001, 32'h202, 32'h0, 32'h8001_7FFF, 32'h0, 5'd10, 1'b1, 0, 1, 1'b0, 4'h0, 32'h0, 32'hFFFF_8001};
        tablo[8]  = '{1, 0, 3'b101, 32'h202, 32'h0, 32'h8001_7FFF, 32'h0, 5'd11, 1'b1, 2, 0, 1'b0, 4'h0, 32'h0, 32'h0000_8001};
        tablo[9]  = '{0, 1, 3'b000, 32'h101, 32'h1234_56A5, 32'h0, 32'h0, 5'd0, 1'b0, 1, 0, 1'b0, 4'h2, 32'hA5A5_A5A5, 32'h0};
        tablo[10] = '{0, 1, 3'b010, 32'h102, 32'h1111_2222, 32'h0, 32'h0, 5'd0, 1'b0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
        tablo[11] = '{1, 0, 3'b010, 32'h2, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
        tablo[12] = '{1, 0, 3'b101, 32'h3, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
        tablo[13] = '{0, 1, 3'b001, 32'h10, 32'hFFFF_1234, 32'h0, 32'h0, 5'd0, 1'b0, 0, 0, 1'b0, 4'h3, 32'h1234_1234, 32'h0};

        turler[0] = 3'b000; turler[1] = 3'b001; turler[2] = 3'b010;
        turler[3] = 3'b100; turler[4] = 3'b101;

        rst_i    = 1'b1;
        durdur_i = 1'b0;
        temizle();
        adim();
        adim();
        chk("reset gecerli", 32'(veri_istek_gecerli_o), 32'd0);
        chk("reset adres", veri_istek_adres_o, 32'd0);
        chk("reset maske", 32'(veri_istek_maske_o), 32'd0);
        chk("reset stall", 32'(bellek_stall_o), 32'd0);
        chk("reset hata", 32'(hizasiz_hata_o), 32'd0);
        chk("reset gy_veri", gy_veri_o, 32'd0);
        chk("reset gy_yy", 32'(gy_yazmaca_yaz_o), 32'd0);
        rst_i = 1'b0;
        adim();

        for (int i = 0; i < 14; i++)
            islem(tablo[i].oku, tablo[i].yaz, tablo[i].tur, tablo[i].adr, tablo[i].wdata, tablo[i].word,
                  tablo[i].alu, tablo[i].rd, tablo[i].yy, tablo[i].hg, tablo[i].yg, tablo[i].hata,
                  tablo[i].maske, tablo[i].wexp, tablo[i].gy, $sformatf("vek%0d", i));

        // durdur_i freezes the writeback register for a plain ALU result
        islem(0, 0, 3'b010, 0, 0, 0, 32'h11, 5'd1, 1'b1, 0, 0, 0, 0, 0, 32'h11, "alu11");
        durdur_i = 1'b1;
        hedef_yazmac_verisi_i = 32'h77; hedef_yazmaci_i = 5'd3; yazmaca_yaz_i = 1'b1;
        adim();
        chk("durdur gy hold", gy_veri_o, 32'h11);
        durdur_i = 1'b0;
        adim();
        chk("durdur release gy", gy_veri_o, 32'h77);

        // durdur_i blocks request launch in BOSTA and holds TAMAM
        durdur_i = 1'b1;
        bellege_yaz_i = 1'b1; load_save_buyrugu_i = 3'b010; bellek_adresi_i = 32'h80;
        bellek_veri_i = 32'hCAFE_0001; yazmaca_yaz_i = 1'b0;
        adim();
        chk("durdur no request", 32'(veri_istek_gecerli_o), 32'd0);
        durdur_i = 1'b0;
        adim();
        chk("durdur then request", 32'(veri_istek_gecerli_o), 32'd1);
        veri_istek_hazir_i = 1'b1;
        adim();
        veri_istek_hazir_i = 1'b0;
        durdur_i = 1'b1;
        adim();
        chk("TAMAM held stall", 32'(bellek_stall_o), 32'd0);
        chk("TAMAM held gy_yy", 32'(gy_yazmaca_yaz_o), 32'd1);
        durdur_i = 1'b0;
        adim();
        temizle();
        chk("TAMAM released gy_yy", 32'(gy_yazmaca_yaz_o), 32'd0);

        // reset while waiting for a read response; the late response must be ignored
        bellekten_oku_i = 1'b1; load_save_buyrugu_i = 3'b010; bellek_adresi_i = 32'h40;
        yazmaca_yaz_i = 1'b1; hedef_yazmaci_i = 5'd12;
        adim();
        veri_istek_hazir_i = 1'b1;
        adim();
        veri_istek_hazir_i = 1'b0;
        adim();
        temizle();
        rst_i = 1'b1;
        #1;
        chk("rst async gecerli", 32'(veri_istek_gecerli_o), 32'd0);
        chk("rst async adres", veri_istek_adres_o, 32'd0);
        chk("rst async gy_veri", gy_veri_o, 32'd0);
        chk("rst async gy_rd", 32'(gy_hedef_yazmaci_o), 32'd0);
        chk("rst async stall", 32'(bellek_stall_o), 32'd0);
        adim();
        rst_i = 1'b0;
        veri_yanit_gecerli_i = 1'b1; veri_yanit_i = 32'h1234_5678;
        adim();
        veri_yanit_gecerli_i = 1'b0;
        adim();
        chk("late yanit gy_veri", gy_veri_o, 32'd0);
        chk("late yanit gy_yy", 32'(gy_yazmaca_yaz_o), 32'd0);
        chk("late yanit gecerli", 32'(veri_istek_gecerli_o), 32'd0);

`ifdef BELLEK_ZAMAN_ASIMI_EN
        // no hazir: abort after 4 request cycles
        bellekten_oku_i = 1'b1; load_save_buyrugu_i = 3'b010; bellek_adresi_i = 32'h60;
        yazmaca_yaz_i = 1'b1; hedef_yazmaci_i = 5'd8;
        adim();
        for (int i = 0; i < 3; i++) adim();
        chk("timeout gecerli before", 32'(veri_istek_gecerli_o), 32'd1);
        chk("timeout stall before", 32'(bellek_stall_o), 32'd1);
        adim();
        chk("timeout hata", 32'(hizasiz_hata_o), 32'd1);
        chk("timeout gecerli dropped", 32'(veri_istek_gecerli_o), 32'd0);
        chk("timeout stall released", 32'(bellek_stall_o), 32'd0);
        adim();
        temizle();
        chk("timeout gy_yy", 32'(gy_yazmaca_yaz_o), 32'd0);
        chk("timeout hata pulse", 32'(hizasiz_hata_o), 32'd0);
`else
        // no timeout: the request stays up as long as hazir is withheld
        bellege_yaz_i = 1'b1; load_save_buyrugu_i = 3'b010; bellek_adresi_i = 32'h60;
        adim();
        for (int i = 0; i < 20; i++) adim();
        chk("no timeout gecerli", 32'(veri_istek_gecerli_o), 32'd1);
        chk("no timeout stall", 32'(bellek_stall_o), 32'd1);
        chk("no timeout hata", 32'(hizasiz_hata_o), 32'd0);
        veri_istek_hazir_i = 1'b1;
        adim();
        veri_istek_hazir_i = 1'b0;
        chk("no timeout finish stall", 32'(bellek_stall_o), 32'd0);
        adim();
        temizle();
`endif

        for (int n = 0; n < 150; n++) begin
            r   = $urandom_range(0, 9);
            o   = (r >= 2 && r <= 5) || r == 9;
            y   = (r >= 6);
            t   = turler[$urandom_range(0, 4)];
            a   = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 1) == 0) a = a & ~32'(boyut(t) - 1);
            d   = $urandom;
            w   = $urandom;
            alu = $urandom;
            rd  = 5'($urandom);
            yy  = 1'($urandom);
            islem(o, y, t, a, d, w, alu, rd, yy, $urandom_range(0, 2), $urandom_range(0, 2),
                  (o || y) && ref_hizasiz(t, a), ref_maske(t, a), ref_yazma(t, d),
                  (o || y) ? ref_yukleme(t, a, w) : alu, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
